// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Drives the board LEDs with a pattern that advances on a programmable slow
// tick. A counter divides the fabric clock down to a one-cycle tick; a small
// FSM (IDLE -> START -> RUN) loads a mode-specific start pattern and then
// steps it on every tick. A valid/ready config port writes a one-entry shadow
// (mode + divisor) that takes effect only at a safe point: immediately while
// idle/starting, or in place of a pattern step at the next tick while running,
// so the visible pattern and tick period never glitch.
//
// Ports:
//   clock      : single clock for all logic
//   reset      : synchronous, active-high reset
//   run        : enables sequencing; low returns to IDLE with LEDs dark
//   cfg_valid  : config request
//   cfg_ready  : high while the shadow slot is free
//   cfg_mode   : 0 OFF, 1 WALK, 2 BLINK, 3 BOUNCE
//   cfg_div    : clock cycles per tick (0 and 1 both mean every cycle)
//   tick       : registered one-cycle pulse per divider period while running
//   leds       : registered LED pattern
//   busy       : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int unsigned          NUM_LEDS     = 4,
  parameter int unsigned          DIV_WIDTH    = 32,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV  = 100_000_000,
  parameter logic [1:0]           DEFAULT_MODE = 2'd2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_mode,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 tick,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  // Registered state
  state_e                 state_q,       state_d;
  logic [DIV_WIDTH-1:0]   cnt_q,         cnt_d;
  dir_e                   dir_q,         dir_d;
  logic [NUM_LEDS-1:0]    leds_q,        leds_d;
  logic                   tick_q,        tick_d;
  logic                   pending_q,     pending_d;
  mode_e                  shadow_mode_q, shadow_mode_d;
  logic [DIV_WIDTH-1:0]   shadow_div_q,  shadow_div_d;
  mode_e                  active_mode_q, active_mode_d;
  logic [DIV_WIDTH-1:0]   active_div_q,  active_div_d;

  // Helpers
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [DIV_WIDTH-1:0]   term_count;
  logic                   at_terminal;
  logic                   cfg_fire;
  logic                   apply_shadow;
  logic [NUM_LEDS-1:0]    walk_next;
  logic [NUM_LEDS-1:0]    bounce_up;
  logic [NUM_LEDS-1:0]    bounce_down;

  // A divisor of 0 is treated as 1 so the terminal count never underflows.
  assign div_eff     = (active_div_q == '0) ? DIV_ONE : active_div_q;
  assign term_count  = div_eff - DIV_ONE;
  assign at_terminal = (cnt_q == term_count);

  // The shadow is a single slot: new requests are refused while it is full.
  assign cfg_fire    = cfg_valid && !pending_q;

  assign walk_next   = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
  assign bounce_up   = leds_q << 1;
  assign bounce_down = leds_q >> 1;

  function automatic logic [NUM_LEDS-1:0] start_value(input mode_e mode);
    case (mode)
      MODE_WALK,
      MODE_BOUNCE: start_value = NUM_LEDS'(1);
      MODE_BLINK:  start_value = '1;
      default:     start_value = '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    leds_d        = leds_q;
    tick_d        = 1'b0;
    pending_d     = pending_q;
    shadow_mode_d = shadow_mode_q;
    shadow_div_d  = shadow_div_q;
    active_mode_d = active_mode_q;
    active_div_d  = active_div_q;
    apply_shadow  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        leds_d = '0;
        dir_d  = DIR_UP;
        // Nothing is visible while idle, so a pending config lands at once.
        apply_shadow = pending_q;
        if (run) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        apply_shadow = pending_q;
        cnt_d        = '0;
        dir_d        = DIR_UP;
        if (run) begin
          state_d = ST_RUN;
          // A config landing on this edge must seed the pattern it selects.
          leds_d  = start_value(pending_q ? shadow_mode_q : active_mode_q);
        end else begin
          state_d = ST_IDLE;
          leds_d  = '0;
        end
      end

      ST_RUN: begin
        if (!run) begin
          // Dropping run wins over a tick; a pending config waits for IDLE.
          state_d = ST_IDLE;
          cnt_d   = '0;
          leds_d  = '0;
          dir_d   = DIR_UP;
        end else if (at_terminal) begin
          tick_d = 1'b1;
          cnt_d  = '0;
          if (pending_q) begin
            // The new config replaces this step rather than following it.
            apply_shadow = 1'b1;
            leds_d       = start_value(shadow_mode_q);
            dir_d        = DIR_UP;
          end else begin
            case (active_mode_q)
              MODE_OFF:   leds_d = '0;
              MODE_WALK:  leds_d = walk_next;
              MODE_BLINK: leds_d = ~leds_q;
              MODE_BOUNCE: begin
                // Flip direction on the step that reaches an end, so the end
                // LED is shown once and the next step heads back inward.
                if (dir_q == DIR_UP) begin
                  leds_d = bounce_up;
                  if (bounce_up[NUM_LEDS-1]) begin
                    dir_d = DIR_DOWN;
                  end
                end else begin
                  leds_d = bounce_down;
                  if (bounce_down[0]) begin
                    dir_d = DIR_UP;
                  end
                end
              end
            endcase
          end
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        leds_d  = '0;
        dir_d   = DIR_UP;
      end
    endcase

    if (apply_shadow) begin
      active_mode_d = shadow_mode_q;
      active_div_d  = shadow_div_q;
      pending_d     = 1'b0;
    end

    // cfg_fire and apply_shadow are mutually exclusive (one needs the slot
    // empty, the other full), so a capture never collides with an apply.
    if (cfg_fire) begin
      shadow_mode_d = mode_e'(cfg_mode);
      shadow_div_d  = cfg_div;
      pending_d     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      leds_q        <= '0;
      tick_q        <= 1'b0;
      pending_q     <= 1'b0;
      shadow_mode_q <= MODE_OFF;
      shadow_div_q  <= '0;
      active_mode_q <= mode_e'(DEFAULT_MODE);
      active_div_q  <= DEFAULT_DIV;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      leds_q        <= leds_d;
      tick_q        <= tick_d;
      pending_q     <= pending_d;
      shadow_mode_q <= shadow_mode_d;
      shadow_div_q  <= shadow_div_d;
      active_mode_q <= active_mode_d;
      active_div_q  <= active_div_d;
    end
  end

  assign leds      = leds_q;
  assign tick      = tick_q;
  assign cfg_ready = !pending_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
